// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 code constants and the receive-frame state type.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_REL    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  // Bytes swallowed after E1 before the single Pause event is emitted.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  // Controller replies carry no key information and cancel pending prefixes.
  function automatic logic is_reply(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_RESEND) ||
           (b == PS2_ECHO) || (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Bundle between the PS/2 pins/keyboard matrix side and the key decoder.
// Signalling: ps2_clk/ps2_data are raw asynchronous levels. rx_valid, rx_error
// and key_strobe are single-cycle pulses with no back-pressure (no ready); the
// consumer must take rx_byte / ps2_key in the cycle the pulse is high.
// rx_state exposes the frame FSM state for observation.
interface ps2_key_decoder_if;
  import ps2_pkg::*;

  logic         ps2_clk;
  logic         ps2_data;
  logic [10:0]  ps2_key;
  logic         key_strobe;
  logic [7:0]   rx_byte;
  logic         rx_valid;
  logic         rx_error;
  frame_state_e rx_state;

  modport master (
    output ps2_clk, ps2_data,
    input  ps2_key, key_strobe, rx_byte, rx_valid, rx_error, rx_state
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output ps2_key, key_strobe, rx_byte, rx_valid, rx_error, rx_state
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 byte receiver: synchroniser, glitch filter, clock-fall detect,
// 11-bit frame FSM with odd-parity/stop check and a mid-frame timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 65536
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic [7:0]   rx_byte,
  output logic         rx_valid,
  output logic         rx_error,
  output frame_state_e state
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  // Index 0 carries ps2_clk, index 1 carries ps2_data.
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    filt_q, filt_d;
  logic [FW-1:0] fcnt_q [2];
  logic [FW-1:0] fcnt_d [2];
  logic          clk_prev_q;
  logic          fall;

  frame_state_e  state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_error_q, rx_error_d;
  logic [TW-1:0] tmo_q, tmo_d;

  // A filtered level only flips after FILTER_LEN consecutive opposite samples.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      fcnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
          filt_d[i] = sync2_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign fall = clk_prev_q & ~filt_q[0];

  // Frame FSM and timeout: one step per filtered ps2_clk fall.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    rx_error_d = 1'b0;
    tmo_d      = tmo_q;

    if (fall || state_q == ST_IDLE) begin
      tmo_d = '0;
    end else if (tmo_q != TW'(TIMEOUT)) begin
      tmo_d = tmo_q + 1'b1;
    end

    if (fall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!filt_q[1]) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d = {filt_q[1], shift_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
          else                   bit_cnt_d = bit_cnt_q + 1'b1;
        end
        ST_PARITY: begin
          par_d   = filt_q[1];
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if ((^{par_q, shift_q}) && filt_q[1]) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = shift_q;
          end else begin
            rx_error_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmo_q == TW'(TIMEOUT)) begin
      rx_error_d = 1'b1;
      state_d    = ST_IDLE;
    end
  end

  // Registers; both filters preload to the idle-high bus level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      fcnt_q[0]  <= '0;
      fcnt_q[1]  <= '0;
      clk_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_error_q <= 1'b0;
      tmo_q      <= '0;
    end else begin
      sync1_q    <= {ps2_data, ps2_clk};
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      fcnt_q[0]  <= fcnt_d[0];
      fcnt_q[1]  <= fcnt_d[1];
      clk_prev_q <= filt_q[0];
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      rx_error_q <= rx_error_d;
      tmo_q      <= tmo_d;
    end
  end

  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign rx_error = rx_error_q;
  assign state    = state_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// Folds E0/F0/E1 prefixes from the PS/2 byte stream into one 11-bit key event.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 65536
) (
  input logic               clk,
  input logic               reset_n,
  ps2_key_decoder_if.slave  bus
);

  logic [7:0]   rx_byte;
  logic         rx_valid;
  logic         rx_error;
  frame_state_e rx_state;

  logic         ext_q, ext_d;
  logic         rel_q, rel_d;
  logic [2:0]   skip_q, skip_d;
  logic [10:0]  key_q, key_d;
  logic         strobe_q, strobe_d;

  ps2_rx_frame #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) u_rx (
    .clk      (clk),
    .rst_n    (reset_n),
    .ps2_clk  (bus.ps2_clk),
    .ps2_data (bus.ps2_data),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_error (rx_error),
    .state    (rx_state)
  );

  // Prefix tracking and event generation for each received byte.
  always_comb begin
    ext_d    = ext_q;
    rel_d    = rel_q;
    skip_d   = skip_q;
    key_d    = key_q;
    strobe_d = 1'b0;

    if (rx_error) begin
      ext_d  = 1'b0;
      rel_d  = 1'b0;
      skip_d = '0;
    end else if (rx_valid) begin
      if (skip_q != '0) begin
        // Inside the Pause sequence: swallow, emit a single press at the end.
        skip_d = skip_q - 1'b1;
        if (skip_q == 3'd1) begin
          key_d    = {~key_q[10], 1'b1, 1'b0, PS2_PAUSE};
          strobe_d = 1'b1;
          ext_d    = 1'b0;
          rel_d    = 1'b0;
        end
      end else if (rx_byte == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == PS2_REL) begin
        rel_d = 1'b1;
      end else if (rx_byte == PS2_PAUSE) begin
        skip_d = PAUSE_SKIP;
      end else if (is_reply(rx_byte)) begin
        ext_d = 1'b0;
        rel_d = 1'b0;
      end else begin
        key_d    = {~key_q[10], ~rel_q, ext_q, rx_byte};
        strobe_d = 1'b1;
        ext_d    = 1'b0;
        rel_d    = 1'b0;
      end
    end
  end

  // Prefix flags and the event register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_q    <= 1'b0;
      rel_q    <= 1'b0;
      skip_q   <= '0;
      key_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      ext_q    <= ext_d;
      rel_q    <= rel_d;
      skip_q   <= skip_d;
      key_q    <= key_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.ps2_key    = key_q;
  assign bus.key_strobe = strobe_q;
  assign bus.rx_byte    = rx_byte;
  assign bus.rx_valid   = rx_valid;
  assign bus.rx_error   = rx_error;
  assign bus.rx_state   = rx_state;

endmodule
